// File: rtl/tc_ram_pkg.sv
// rtl/tc_ram_pkg.sv - shared widths and FSM encodings for the fast-RAM burst sequencer
package tc_ram_pkg;

  localparam int LANE_W = 64;
  localparam int LANES  = 4;
  localparam int WORD_W = LANES * LANE_W;
  localparam int ADDR_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/tc_ram_rd_hold.sv
// rtl/tc_ram_rd_hold.sv - single-entry valid/ready holding register for read data
module tc_ram_rd_hold
  import tc_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [WORD_W-1:0] s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [WORD_W-1:0] m_tdata
);

  // Space is available when empty or when the current word leaves this cycle.
  assign s_tready = !m_tvalid || m_tready;

  // Capture a new word, drop the held word on handshake, or discard it on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (flush) begin
      m_tvalid <= 1'b0;
    end else if (s_tvalid && s_tready) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/tc_ram_burst_ctrl.sv
// rtl/tc_ram_burst_ctrl.sv - burst sequencer driving the fast RAM block from write/read streams
module tc_ram_burst_ctrl
  import tc_ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              abort,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  output logic              ram_save,
  output logic [LANE_W-1:0] ram_in0,
  output logic [LANE_W-1:0] ram_in1,
  output logic [LANE_W-1:0] ram_in2,
  output logic [LANE_W-1:0] ram_in3,
  input  logic [LANE_W-1:0] ram_out0,
  input  logic [LANE_W-1:0] ram_out1,
  input  logic [LANE_W-1:0] ram_out2,
  input  logic [LANE_W-1:0] ram_out3
);

  logic [1:0]        state;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] next_addr;
  logic              rd_pend;   // address on the RAM whose word is not yet captured
  logic              wr_fin;    // final write beat is on the RAM this cycle
  logic              kill;
  logic              wr_beat;
  logic              rd_issue;
  logic              rd_last;
  logic              hold_ready;
  logic [WORD_W-1:0] ram_word;

  assign req_ready = (state == ST_IDLE);
  assign wr_ready  = (state == ST_WRITE);
  assign ram_word  = {ram_out3, ram_out2, ram_out1, ram_out0};
  assign next_addr = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;

  assign kill     = abort && (state != ST_IDLE);
  assign wr_beat  = (state == ST_WRITE) && wr_valid && !abort;
  // The RAM output is combinational from the address, so an uncaptured word simply
  // waits on the bus; a new address may replace it only once the hold takes it.
  assign rd_issue = (state == ST_READ) && !abort && (!rd_pend || hold_ready);
  assign rd_last  = (state == ST_DRAIN) && !abort && !rd_pend && rd_valid && rd_ready;

  // Burst FSM, address/count tracking and registered RAM-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      addr        <= '0;
      rd_pend     <= 1'b0;
      wr_fin      <= 1'b0;
      done        <= 1'b0;
      ram_address <= '0;
      ram_load    <= 1'b0;
      ram_save    <= 1'b0;
      ram_in0     <= '0;
      ram_in1     <= '0;
      ram_in2     <= '0;
      ram_in3     <= '0;
    end else begin
      ram_save <= wr_beat;
      wr_fin   <= wr_beat && (cnt == '0);
      done     <= kill || wr_fin || rd_last;
      if (kill) begin
        state    <= ST_IDLE;
        ram_load <= 1'b0;
        rd_pend  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req_valid) begin
              state <= req_write ? ST_WRITE : ST_READ;
              addr  <= ADDR_W'(req_addr % DEPTH);
              cnt   <= req_len;
            end
          end
          ST_WRITE: begin
            if (wr_beat) begin
              ram_address <= addr;
              ram_in0     <= wr_data[0*LANE_W +: LANE_W];
              ram_in1     <= wr_data[1*LANE_W +: LANE_W];
              ram_in2     <= wr_data[2*LANE_W +: LANE_W];
              ram_in3     <= wr_data[3*LANE_W +: LANE_W];
              addr        <= next_addr;
              cnt         <= cnt - 1'b1;
              if (cnt == '0) state <= ST_IDLE;
            end
          end
          ST_READ: begin
            if (rd_issue) begin
              ram_address <= addr;
              ram_load    <= 1'b1;
              rd_pend     <= 1'b1;
              addr        <= next_addr;
              cnt         <= cnt - 1'b1;
              if (cnt == '0) state <= ST_DRAIN;
            end else if (rd_pend && hold_ready) begin
              rd_pend <= 1'b0;
            end
          end
          default: begin
            if (rd_pend && hold_ready) rd_pend <= 1'b0;
            if (rd_last) begin
              state    <= ST_IDLE;
              ram_load <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  tc_ram_rd_hold u_rd_hold (
    .clk      (clk),
    .rst      (rst),
    .flush    (kill),
    .s_tvalid (rd_pend && !abort),
    .s_tready (hold_ready),
    .s_tdata  (ram_word),
    .m_tvalid (rd_valid),
    .m_tready (rd_ready),
    .m_tdata  (rd_data)
  );

endmodule
